// File: rtl/frv_pipeline_fetch.sv
// Fetch stage: sequential word fetch into a small FIFO, s1 valid/busy handshake to decode, cf redirect/flush.
// Optional FRV_FETCH_ERR_HALT_EN: a bus-errored fetch stops further requests until the next cf_ack.
`timescale 1ns/1ps
module frv_pipeline_fetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_ADDR = 32'h80000000
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        cf_req,
    input  logic [31:0] cf_target,
    output logic        cf_ack,
    output logic        imem_cen,
    output logic [31:0] imem_addr,
    input  logic        imem_stall,
    input  logic        imem_error,
    input  logic [31:0] imem_rdata,
    output logic        s1_p_valid,
    input  logic        s1_p_busy,
    output logic [31:0] s1_data,
    output logic [31:0] s1_pc,
    output logic        s1_error
);
    localparam int          AW    = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);

    logic [31:0]   r_mem_data [FIFO_DEPTH];
    logic [31:0]   r_mem_pc   [FIFO_DEPTH];
    logic          r_mem_err  [FIFO_DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;
    logic [31:0]   r_fetch_pc;
    logic          r_held;
    logic          r_boot;
    logic          w_halted, w_cen, w_ack, w_accept, w_push, w_pop, w_valid;
    logic          w_unused;

    // r_boot masks requests and acks for the first cycle after reset.
    assign w_cen    = !g_reset && !r_boot &&
                      (r_held || (r_count < DEPTH && !cf_req && !w_halted));
    assign w_ack    = !g_reset && !r_boot && cf_req && !(w_cen && imem_stall);
    assign w_accept = w_cen && !imem_stall;
    assign w_push   = w_accept && !w_ack;
    assign w_valid  = !g_reset && (r_count != '0);
    assign w_pop    = w_valid && !s1_p_busy;
    assign w_unused = ^cf_target[1:0];

    assign cf_ack     = w_ack;
    assign imem_cen   = w_cen;
    assign imem_addr  = r_fetch_pc;
    assign s1_p_valid = w_valid;
    assign s1_data    = w_valid ? r_mem_data[r_head] : 32'h0;
    assign s1_pc      = w_valid ? r_mem_pc[r_head]   : 32'h0;
    assign s1_error   = w_valid ? r_mem_err[r_head]  : 1'b0;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            r_boot     <= 1'b1;
            r_held     <= 1'b0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_fetch_pc <= RESET_ADDR;
        end else begin
            r_boot <= 1'b0;
            r_held <= w_cen && imem_stall;
            if (w_ack) begin
                // Decode still consumes a same-cycle pop; the flush discards everything else.
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_fetch_pc <= {cf_target[31:2], 2'b00};
            end else begin
                if (w_push) begin
                    r_tail     <= r_tail + AW'(1);
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_pop)
                    r_head <= r_head + AW'(1);
                r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (w_push) begin
            r_mem_data[r_tail] <= imem_rdata;
            r_mem_pc[r_tail]   <= r_fetch_pc;
            r_mem_err[r_tail]  <= imem_error;
        end
    end

`ifdef FRV_FETCH_ERR_HALT_EN
    logic r_halted;
    always_ff @(posedge g_clk) begin
        if (g_reset || w_ack)
            r_halted <= 1'b0;
        else if (w_push && imem_error)
            r_halted <= 1'b1;
    end
    assign w_halted = r_halted;
`else
    assign w_halted = 1'b0;
`endif

endmodule

// File: tb/tb_frv_pipeline_fetch.sv
// Bench for frv_pipeline_fetch: directed scenarios plus randomized traffic checked against a queue model.
`timescale 1ns/1ps
module tb_frv_pipeline_fetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RADDR = 32'h80000000;
`ifdef FRV_FETCH_ERR_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    logic        g_clk = 1'b0;
    logic        g_reset, cf_req, cf_ack, imem_cen, imem_stall, imem_error;
    logic        s1_p_valid, s1_p_busy, s1_error;
    logic [31:0] cf_target, imem_addr, imem_rdata, s1_data, s1_pc;

    always #5 g_clk = ~g_clk;

    frv_pipeline_fetch #(.FIFO_DEPTH(DEPTH), .RESET_ADDR(RADDR)) dut (
        .g_clk(g_clk), .g_reset(g_reset), .cf_req(cf_req), .cf_target(cf_target), .cf_ack(cf_ack),
        .imem_cen(imem_cen), .imem_addr(imem_addr), .imem_stall(imem_stall), .imem_error(imem_error),
        .imem_rdata(imem_rdata), .s1_p_valid(s1_p_valid), .s1_p_busy(s1_p_busy), .s1_data(s1_data),
        .s1_pc(s1_pc), .s1_error(s1_error)
    );

    typedef struct {
        logic        err;
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_held, m_halted, m_boot;
    int          n_chk = 0, n_fail = 0;
    logic        o_cen, o_ack, o_val, o_err;
    logic [31:0] o_addr, o_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: drive inputs, compare every output with the model, then advance the model.
    task automatic cyc(input bit rst, input bit req, input logic [31:0] tgt, input bit stall,
                       input bit err, input logic [31:0] rd, input bit busy);
        bit   e_cen, e_ack, e_val;
        ent_t h;
        @(posedge g_clk); #1;
        g_reset = rst; cf_req = req; cf_target = tgt; imem_stall = stall;
        imem_error = err; imem_rdata = rd; s1_p_busy = busy;
        #2;
        if (rst || m_boot) begin
            e_cen = 1'b0; e_ack = 1'b0; e_val = 1'b0;
        end else begin
            e_cen = m_held || (q.size() < DEPTH && !req && !m_halted);
            e_ack = req && !(e_cen && stall);
            e_val = q.size() != 0;
        end
        h = '{default: '0};
        if (e_val) h = q[0];
        chk("cen", imem_cen, e_cen);
        if (e_cen) chk("addr", imem_addr, m_pc);
        chk("ack", cf_ack, e_ack);
        chk("valid", s1_p_valid, e_val);
        chk("s1_data", s1_data, h.data);
        chk("s1_pc", s1_pc, h.pc);
        chk("s1_error", s1_error, h.err);
        o_cen = imem_cen; o_addr = imem_addr; o_ack = cf_ack;
        o_val = s1_p_valid; o_pc = s1_pc; o_err = s1_error;
        if (rst) begin
            q.delete(); m_pc = RADDR; m_held = 1'b0; m_halted = 1'b0; m_boot = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            if (e_val && !busy) void'(q.pop_front());
            m_held = e_cen && stall;
            if (e_ack) begin
                q.delete(); m_pc = {tgt[31:2], 2'b00}; m_halted = 1'b0;
            end else if (e_cen && !stall) begin
                q.push_back('{err, m_pc, rd});
                m_pc = m_pc + 32'd4;
                if (HALT && err) m_halted = 1'b1;
            end
        end
    endtask

    task automatic go(input bit req = 0, input logic [31:0] tgt = 0, input bit stall = 0,
                      input bit err = 0, input bit busy = 0);
        cyc(1'b0, req, tgt, stall, err, $urandom, busy);
    endtask

    task automatic rst();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        g_reset = 1'b1; cf_req = 1'b0; cf_target = '0; imem_stall = 1'b0;
        imem_error = 1'b0; imem_rdata = '0; s1_p_busy = 1'b0;

        // Reset release and streaming.
        rst();
        go(); chk("t1_boot_cen", o_cen, 0); chk("t1_boot_val", o_val, 0);
        go(); chk("t1_cen", o_cen, 1); chk("t1_addr0", o_addr, 32'h80000000);
        go(); chk("t1_addr1", o_addr, 32'h80000004); chk("t1_pc0", o_pc, 32'h80000000);
        go(); chk("t1_addr2", o_addr, 32'h80000008); chk("t1_pc1", o_pc, 32'h80000004);

        // Decode busy: buffer fills to four, then refetch after drain starts.
        rst(); go(.busy(1));
        for (int i = 0; i < 4; i++) begin
            go(.busy(1)); chk("t2_fill_addr", o_addr, 32'h80000000 + 32'(4 * i));
        end
        go(.busy(1)); chk("t2_full_cen", o_cen, 0); chk("t2_head", o_pc, 32'h80000000);
        go(); chk("t2_pop_cen", o_cen, 0); chk("t2_pop_pc", o_pc, 32'h80000000);
        go(); chk("t2_refetch", o_addr, 32'h80000010); chk("t2_pc1", o_pc, 32'h80000004);
        for (int i = 0; i < 10; i++) go(.busy(($urandom % 2) == 0));

        // Stall with a redirect arriving mid-stall.
        rst(); go(); go();
        go(.stall(1)); chk("t3_st_addr", o_addr, 32'h80000004);
        go(.req(1), .tgt(32'h00001002), .stall(1));
        chk("t3_st_ack", o_ack, 0); chk("t3_st_cen", o_cen, 1); chk("t3_st_addr2", o_addr, 32'h80000004);
        go(.req(1), .tgt(32'h00001002), .stall(1)); chk("t3_st_ack2", o_ack, 0);
        go(.req(1), .tgt(32'h00001002)); chk("t3_ack", o_ack, 1);
        go(); chk("t3_tgt", o_addr, 32'h00001000); chk("t3_flush", o_val, 0);

        // Bus error on the third fetch.
        rst(); go(); go(); go(); go(.err(1));
        go(); chk("t5_pc", o_pc, 32'h80000008); chk("t5_err", o_err, 1); chk("t5_cen", o_cen, !HALT);
        go(); go(.req(1), .tgt(32'h80000100)); chk("t5_ack", o_ack, 1);
        go(); chk("t5_redir", o_addr, 32'h80000100);

        // Address wrap, then reset during a stall.
        rst(); go(); go(.req(1), .tgt(32'hFFFFFFFF)); chk("t6_ack", o_ack, 1);
        go(); chk("t6_top", o_addr, 32'hFFFFFFFC);
        go(); chk("t6_wrap", o_addr, 32'h00000000);
        go(.stall(1)); chk("t6_st_cen", o_cen, 1);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0); chk("t6_rst_cen", o_cen, 0);
        go(.stall(1)); chk("t6_after_cen", o_cen, 0); chk("t6_after_val", o_val, 0);
        go(); chk("t6_restart", o_addr, RADDR);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 300) == 0, ($urandom % 12) == 0, $urandom, ($urandom % 4) == 0,
                ($urandom % 10) == 0, $urandom, ($urandom % 3) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
